// File: rtl/data_ram_responder_pkg.sv
// Shared memory-map constants for the data-RAM responder: MMIO window base, register
// offsets and the STATUS word layout.
package data_ram_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

    typedef enum logic [2:0] {
        OFF_CONSOLE_TX = 3'd0,
        OFF_STATUS     = 3'd1,
        OFF_TIMER_LO   = 3'd2,
        OFF_TIMER_HI   = 3'd3,
        OFF_HALT       = 3'd4
    } mmio_off_e;

    localparam int STATUS_COUNT_W      = 9;
    localparam int STATUS_EMPTY_BIT    = 9;
    localparam int STATUS_FULL_BIT     = 10;
    localparam int STATUS_OVERFLOW_BIT = 11;

    function automatic logic [31:0] pack_status(
        input logic                      overflow,
        input logic                      full,
        input logic                      empty,
        input logic [STATUS_COUNT_W-1:0] count
    );
        logic [31:0] word;
        word                      = '0;
        word[STATUS_COUNT_W-1:0]  = count;
        word[STATUS_EMPTY_BIT]    = empty;
        word[STATUS_FULL_BIT]     = full;
        word[STATUS_OVERFLOW_BIT] = overflow;
        return word;
    endfunction

endpackage

// File: rtl/data_ram_responder_console_fifo.sv
// Synchronous FIFO feeding the console TX stream. Head entry is visible combinationally;
// a push arriving while full is refused unless a pop frees a slot in the same cycle.
module data_ram_responder_console_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LOG2:0]    count_o,
    output logic             drop_o
);

    localparam int DEPTH = 2 ** LOG2;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (LOG2 + 1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign data_o  = buf_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder: zero-latency word RAM with byte-lane stores, plus an MMIO window
// holding the console TX FIFO, a 64-bit cycle timer with hi-word shadow, and a sticky halt.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 14,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
    parameter int          FIFO_LOG2   = 3,
    parameter logic [63:0] TIMER_RESET = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        halt_o,
    output logic [7:0]  halt_code_o
);

    localparam int RAM_WORDS = 2 ** DEPTH_LOG2;

    logic                  active;
    logic                  mmio_hit;
    mmio_off_e             mmio_off;
    logic                  ram_wr;
    logic                  mmio_wr;
    logic                  mmio_rd;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [31:0]           ram_rd_word;
    logic                  unused_addr_bits;

    // Byte offset within the word has no meaning for a word-wide port.
    assign unused_addr_bits = ^mem_addr_i[1:0];

    assign active   = rst & mem_ce_i;
    assign mmio_hit = (mem_addr_i[31:16] == MMIO_BASE[31:16]);
    assign mmio_off = mmio_off_e'(mem_addr_i[4:2]);
    assign ram_idx  = mem_addr_i[DEPTH_LOG2+1:2];
    assign ram_wr   = active &  mem_we_i & ~mmio_hit;
    assign mmio_wr  = active &  mem_we_i &  mmio_hit;
    assign mmio_rd  = active & ~mem_we_i &  mmio_hit;

    // One narrow array per byte lane, so a masked store is just independent lane enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [RAM_WORDS];

        always_ff @(posedge clk) begin
            if (ram_wr && mem_sel_i[gi]) lane_q[ram_idx] <= mem_data_i[8*gi +: 8];
        end

        assign ram_rd_word[8*gi +: 8] = lane_q[ram_idx];
    end

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_drop;
    logic [FIFO_LOG2:0]   fifo_count;

    assign fifo_push = mmio_wr & (mmio_off == OFF_CONSOLE_TX) & mem_sel_i[0];
    assign fifo_pop  = tx_valid_o & tx_ready_i;

    data_ram_responder_console_fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) u_console_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (mem_data_i[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (tx_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    assign tx_valid_o = ~fifo_empty;

    logic [63:0] timer_q, timer_d;
    logic [31:0] shadow_q, shadow_d;
    logic        overflow_q, overflow_d;
    logic        halt_q, halt_d;
    logic [7:0]  halt_code_q, halt_code_d;

    always_comb begin
        timer_d     = timer_q + 64'd1;
        shadow_d    = shadow_q;
        overflow_d  = overflow_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        // Snapshot hi on the lo read so a later hi read pairs with it even across a carry.
        if (mmio_rd && mmio_off == OFF_TIMER_LO) shadow_d = timer_q[63:32];
        if (fifo_drop) overflow_d = 1'b1;
        if (mmio_wr && mmio_off == OFF_STATUS) overflow_d = 1'b0;
        if (mmio_wr && mmio_off == OFF_HALT && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = mem_data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q     <= TIMER_RESET;
            shadow_q    <= '0;
            overflow_q  <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            overflow_q  <= overflow_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
        end
    end

    assign halt_o      = halt_q;
    assign halt_code_o = halt_code_q;

    always_comb begin
        mem_data_o = '0;
        if (active) begin
            if (mmio_hit) begin
                case (mmio_off)
                    OFF_STATUS:   mem_data_o = pack_status(overflow_q, fifo_full, fifo_empty,
                                                           STATUS_COUNT_W'(fifo_count));
                    OFF_TIMER_LO: mem_data_o = timer_q[31:0];
                    OFF_TIMER_HI: mem_data_o = shadow_q;
                    default:      mem_data_o = '0;
                endcase
            end else begin
                mem_data_o = ram_rd_word;
            end
        end
    end

endmodule
